approx_err_stats: RTL and testbench

Streaming error-statistics accumulator sitting directly downstream of the approximate adder under evaluation. Each accepted sample is an (exact, approximate) result pair. The block accumulates the error sum, the squared-error sum, the exact-result sum, and the error minimum and maximum. Software or a bench derives mean, variance and relative error from these totals, which replaces per-run floating-point post-processing with a synthesizable, cycle-accurate stage.

---
 rtl/approx_stats_pkg.sv | 29 ++
 rtl/err_sq_acc.sv | 73 +++++++
 rtl/approx_err_stats.sv | 114 +++++++++++
 tb/tb_approx_err_stats.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_stats_pkg.sv
// Shared definitions for the approximate-adder error statistics slice:
// run-control FSM states and result-width derivations.
package approx_stats_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The error of two signed DATA_W values needs one extra bit.
  function automatic int err_width(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int esum_width(input int data_w, input int cnt_w);
    return err_width(data_w) + cnt_w;
  endfunction

  function automatic int sq_width(input int data_w, input int cnt_w);
    return 2 * err_width(data_w) + cnt_w;
  endfunction

  function automatic int rsum_width(input int data_w, input int cnt_w);
    return data_w + cnt_w;
  endfunction

endpackage

// File: rtl/err_sq_acc.sv
// Square-and-accumulate datapath for the error statistics block: sums of
// error, squared error and exact result, plus error extremes.
module err_sq_acc
  import approx_stats_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 20,
  localparam int ERR_W  = err_width(DATA_W),
  localparam int ESUM_W = esum_width(DATA_W, CNT_W),
  localparam int SQ_W   = sq_width(DATA_W, CNT_W),
  localparam int RSUM_W = rsum_width(DATA_W, CNT_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [ERR_W-1:0]  err_p1,
  input  logic signed [DATA_W-1:0] exact_p1,
  output logic signed [ESUM_W-1:0] err_sum,
  output logic        [SQ_W-1:0]   err_sq_sum,
  output logic signed [RSUM_W-1:0] result_sum,
  output logic signed [ERR_W-1:0]  err_min,
  output logic signed [ERR_W-1:0]  err_max
);

  localparam logic signed [ERR_W-1:0] ERR_POS_MAX = {1'b0, {(ERR_W-1){1'b1}}};
  localparam logic signed [ERR_W-1:0] ERR_NEG_MAX = {1'b1, {(ERR_W-1){1'b0}}};

  // Product is formed at full 2*ERR_W width so even (2^(ERR_W-1))^2 is exact.
  function automatic logic [2*ERR_W-1:0] square(input logic signed [ERR_W-1:0] e);
    logic signed [2*ERR_W-1:0] ew;
    logic signed [2*ERR_W-1:0] p;
    ew = {{ERR_W{e[ERR_W-1]}}, e};
    p  = ew * ew;
    return p;
  endfunction

  function automatic logic signed [ESUM_W-1:0] ext_err(input logic signed [ERR_W-1:0] e);
    return {{CNT_W{e[ERR_W-1]}}, e};
  endfunction

  function automatic logic [SQ_W-1:0] ext_sq(input logic [2*ERR_W-1:0] s);
    return {{CNT_W{1'b0}}, s};
  endfunction

  function automatic logic signed [RSUM_W-1:0] ext_exact(input logic signed [DATA_W-1:0] x);
    return {{CNT_W{x[DATA_W-1]}}, x};
  endfunction

  // ---- stage 2: square and accumulate ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sum    <= '0;
      err_sq_sum <= '0;
      result_sum <= '0;
      err_min    <= '0;
      err_max    <= '0;
    end else if (clr) begin
      err_sum    <= '0;
      err_sq_sum <= '0;
      result_sum <= '0;
      err_min    <= ERR_POS_MAX;
      err_max    <= ERR_NEG_MAX;
    end else if (en) begin
      err_sum    <= err_sum + ext_err(err_p1);
      err_sq_sum <= err_sq_sum + ext_sq(square(err_p1));
      result_sum <= result_sum + ext_exact(exact_p1);
      if (err_p1 < err_min) err_min <= err_p1;
      if (err_p1 > err_max) err_max <= err_p1;
    end
  end

endmodule

// File: rtl/approx_err_stats.sv
// Streaming error-statistics accumulator for (exact, approximate) result
// pairs; holds run control, the accepted-pair counter and the error stage.
module approx_err_stats
  import approx_stats_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 20,
  localparam int ERR_W  = err_width(DATA_W),
  localparam int ESUM_W = esum_width(DATA_W, CNT_W),
  localparam int SQ_W   = sq_width(DATA_W, CNT_W),
  localparam int RSUM_W = rsum_width(DATA_W, CNT_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic        [CNT_W-1:0]  sample_count,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] exact,
  input  logic signed [DATA_W-1:0] appr,
  output logic                     busy,
  output logic                     done,
  output logic signed [ESUM_W-1:0] err_sum,
  output logic        [SQ_W-1:0]   err_sq_sum,
  output logic signed [RSUM_W-1:0] result_sum,
  output logic signed [ERR_W-1:0]  err_min,
  output logic signed [ERR_W-1:0]  err_max,
  output logic        [CNT_W-1:0]  accepted
);

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         cnt_lat;
  logic                     start_ok;
  logic                     xfer;
  logic                     last_xfer;
  logic                     vld_p1;
  logic signed [ERR_W-1:0]  err_p1;
  logic signed [DATA_W-1:0] exact_p1;

  function automatic logic signed [ERR_W-1:0] diff_ext(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [ERR_W-1:0] ae;
    logic signed [ERR_W-1:0] be;
    ae = {a[DATA_W-1], a};
    be = {b[DATA_W-1], b};
    return ae - be;
  endfunction

  // Ready decodes registered state only, so in_valid never loops back.
  assign in_ready  = (state == RUN) && (accepted < cnt_lat);
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (accepted == cnt_lat - CNT_W'(1));
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = (sample_count == '0) ? DONE : RUN;
      RUN:        if (last_xfer) state_nxt = DRAIN;
      DRAIN:      if (!vld_p1) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt_lat  <= '0;
      accepted <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= xfer;
      if (start_ok) begin
        cnt_lat  <= sample_count;
        accepted <= '0;
      end else if (xfer) begin
        accepted <= accepted + CNT_W'(1);
      end
    end
  end

  // ---- stage 1: error formation ----
  always_ff @(posedge clk) begin
    if (xfer) begin
      err_p1   <= diff_ext(appr, exact);
      exact_p1 <= exact;
    end
  end

  // ---- stage 2 ----
  err_sq_acc #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ok),
    .en         (vld_p1),
    .err_p1     (err_p1),
    .exact_p1   (exact_p1),
    .err_sum    (err_sum),
    .err_sq_sum (err_sq_sum),
    .result_sum (result_sum),
    .err_min    (err_min),
    .err_max    (err_max)
  );

endmodule

// File: tb/tb_approx_err_stats.sv
// Directed and randomized bench for approx_err_stats against a plain
// arithmetic model of the error statistics.
module tb_approx_err_stats;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 20;
  localparam int ERR_W  = 33;
  localparam int ESUM_W = 53;
  localparam int SQ_W   = 86;
  localparam int RSUM_W = 52;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic        [CNT_W-1:0]  sample_count;
  logic                     in_valid;
  logic signed [DATA_W-1:0] exact;
  logic signed [DATA_W-1:0] appr;
  wire                      in_ready;
  wire                      busy;
  wire                      done;
  wire signed  [ESUM_W-1:0] err_sum;
  wire         [SQ_W-1:0]   err_sq_sum;
  wire signed  [RSUM_W-1:0] result_sum;
  wire signed  [ERR_W-1:0]  err_min;
  wire signed  [ERR_W-1:0]  err_max;
  wire         [CNT_W-1:0]  accepted;

  approx_err_stats #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_count(sample_count),
    .in_valid(in_valid), .in_ready(in_ready), .exact(exact), .appr(appr),
    .busy(busy), .done(done), .err_sum(err_sum), .err_sq_sum(err_sq_sum),
    .result_sum(result_sum), .err_min(err_min), .err_max(err_max),
    .accepted(accepted)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  longint                   m_esum, m_rsum, m_min, m_max;
  logic signed [127:0]      m_sq;
  int                       m_acc;
  logic signed [DATA_W-1:0] q_ex[$];
  logic signed [DATA_W-1:0] q_ap[$];
  bit                       q_vld[$];

  task automatic chk_s(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_u(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_esum = 0;
    m_rsum = 0;
    m_sq   = '0;
    m_min  = (64'sd1 <<< 32) - 1;
    m_max  = -(64'sd1 <<< 32);
    m_acc  = 0;
  endtask

  task automatic model_add(input logic signed [DATA_W-1:0] ex, input logic signed [DATA_W-1:0] ap);
    longint              e;
    logic signed [127:0] e128;
    e      = longint'(ap) - longint'(ex);
    e128   = e;
    m_esum = m_esum + e;
    m_rsum = m_rsum + longint'(ex);
    m_sq   = m_sq + e128 * e128;
    if (e < m_min) m_min = e;
    if (e > m_max) m_max = e;
  endtask

  task automatic chk_results(input string tag);
    chk_s({tag, "_err_sum"}, err_sum, m_esum);
    chk_u({tag, "_err_sq_sum"}, err_sq_sum, m_sq);
    chk_s({tag, "_result_sum"}, result_sum, m_rsum);
    chk_s({tag, "_err_min"}, err_min, m_min);
    chk_s({tag, "_err_max"}, err_max, m_max);
    chk_u({tag, "_accepted"}, accepted, m_acc);
  endtask

  // Start a run, stream q_ex/q_ap under the q_vld pattern (then valid high),
  // and check ready/done timing every cycle plus the final totals.
  task automatic run_seq(input int count, input string tag);
    int c, pi, since;
    bit xfer, exp_rdy, exp_done;
    model_clear();
    start        = 1'b1;
    sample_count = count[CNT_W-1:0];
    in_valid     = 1'b0;
    step();
    start = 1'b0;
    chk_u({tag, "_ready_after_start"}, in_ready, count != 0);
    chk_u({tag, "_busy_after_start"}, busy, count != 0);
    chk_u({tag, "_done_after_start"}, done, count == 0);
    pi       = 0;
    since    = 2;
    c        = 0;
    exp_done = (count == 0);
    while (!(exp_done && c >= q_vld.size()) && c < 2000) begin
      in_valid = (c < q_vld.size()) ? q_vld[c] : 1'b1;
      if (pi < q_ex.size()) begin
        exact = q_ex[pi];
        appr  = q_ap[pi];
      end else begin
        exact = $urandom;
        appr  = $urandom;
      end
      exp_rdy = (m_acc < count);
      chk_u({tag, "_in_ready"}, in_ready, exp_rdy);
      xfer = in_valid && exp_rdy;
      step();
      if (xfer) begin
        model_add(exact, appr);
        m_acc++;
        pi++;
        since = 0;
      end else begin
        since++;
      end
      exp_done = (m_acc == count) && (since >= 2);
      chk_u({tag, "_accepted_run"}, accepted, m_acc);
      chk_u({tag, "_done"}, done, exp_done);
      chk_u({tag, "_busy"}, busy, !exp_done);
      c++;
    end
    if (c >= 2000) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no_done required=done", tag);
    end
    in_valid = 1'b0;
    chk_results(tag);
    step();
    chk_u({tag, "_done_hold"}, done, 1'b1);
    chk_results({tag, "_hold"});
  endtask

  task automatic load_clear();
    q_ex.delete();
    q_ap.delete();
    q_vld.delete();
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    sample_count = '0;
    in_valid     = 1'b0;
    exact        = '0;
    appr         = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk_u("rst_in_ready", in_ready, 1'b0);
    chk_u("rst_busy", busy, 1'b0);
    chk_u("rst_done", done, 1'b0);
    chk_s("rst_err_sum", err_sum, 0);
    chk_u("rst_err_sq_sum", err_sq_sum, 0);
    chk_s("rst_err_min", err_min, 0);
    chk_s("rst_err_max", err_max, 0);
    chk_u("rst_accepted", accepted, 0);

    // 4-LSB truncation, three pairs
    load_clear();
    q_ex = '{20, 31, 16};
    q_ap = '{16, 16, 16};
    q_vld = '{1, 1, 1};
    run_seq(3, "trunc");
    chk_s("trunc_const_err_sum", err_sum, -19);
    chk_u("trunc_const_sq", err_sq_sum, 241);
    chk_s("trunc_const_rsum", result_sum, 67);
    chk_s("trunc_const_min", err_min, -15);
    chk_s("trunc_const_max", err_max, 0);

    // Empty run
    load_clear();
    run_seq(0, "zero");
    chk_s("zero_const_err_sum", err_sum, 0);
    chk_s("zero_const_min", err_min, (64'sd1 <<< 32) - 1);
    chk_s("zero_const_max", err_max, -(64'sd1 <<< 32));

    // Backpressure: valid for 10 cycles, only 4 accepted
    load_clear();
    for (int i = 0; i < 10; i++) begin
      q_ex.push_back($urandom);
      q_ap.push_back($urandom);
      q_vld.push_back(1'b1);
    end
    run_seq(4, "bp");
    chk_u("bp_const_accepted", accepted, 4);

    // Bubbles: 1,0,0,1 with two pairs
    load_clear();
    q_ex = '{100, -7};
    q_ap = '{96, 9};
    q_vld = '{1, 0, 0, 1};
    run_seq(2, "bub");
    chk_s("bub_const_err_sum", err_sum, 12);
    chk_u("bub_const_sq", err_sq_sum, 272);

    // Extremes
    load_clear();
    q_ex.push_back(32'h8000_0000);
    q_ap.push_back(32'h7FFF_FFFF);
    run_seq(1, "ext1");
    chk_u("ext1_const_sq", err_sq_sum, 128'hFFFF_FFFE_0000_0001);
    chk_s("ext1_const_max", err_max, 64'sd4294967295);
    load_clear();
    q_ex.push_back(32'h8000_0000);
    q_ap.push_back(32'h7FFF_FFFF);
    q_ex.push_back(32'h7FFF_FFFF);
    q_ap.push_back(32'h8000_0000);
    run_seq(2, "ext2");
    chk_s("ext2_const_min", err_min, -64'sd4294967295);
    chk_s("ext2_const_err_sum", err_sum, 0);
    chk_u("ext2_const_sq", err_sq_sum, 128'h1_FFFF_FFFC_0000_0002);

    // Random data with random valid gaps
    for (int r = 0; r < 3; r++) begin
      load_clear();
      for (int i = 0; i < 25; i++) begin
        q_ex.push_back($urandom);
        q_ap.push_back($urandom);
        q_vld.push_back(1'($urandom_range(0, 1)));
      end
      run_seq(20, $sformatf("rnd%0d", r));
    end

    // Reset mid-run after two of five transfers
    model_clear();
    start        = 1'b1;
    sample_count = 5;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    exact    = 7;
    appr     = 3;
    step();
    step();
    in_valid = 1'b0;
    chk_u("mid_accepted", accepted, 2);
    #2;
    rst = 1'b1;
    #1;
    chk_u("mid_rst_in_ready", in_ready, 1'b0);
    chk_u("mid_rst_busy", busy, 1'b0);
    chk_u("mid_rst_done", done, 1'b0);
    chk_s("mid_rst_err_sum", err_sum, 0);
    chk_u("mid_rst_err_sq_sum", err_sq_sum, 0);
    chk_s("mid_rst_result_sum", result_sum, 0);
    chk_s("mid_rst_err_min", err_min, 0);
    chk_s("mid_rst_err_max", err_max, 0);
    chk_u("mid_rst_accepted", accepted, 0);
    step();
    rst = 1'b0;
    step();
    chk_u("post_rst_busy", busy, 1'b0);
    load_clear();
    q_ex = '{5};
    q_ap = '{0};
    q_vld = '{1};
    run_seq(1, "after_rst");
    chk_s("after_rst_const_err_sum", err_sum, -5);
    chk_u("after_rst_const_sq", err_sq_sum, 25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
